wb_ddr3_arbiter: RTL

- Shares the single pipelined Wishbone slave port of the DDR3 controller (64-bit data, 32-bit address, stall/ack/err) between two masters, e.g. a test/DMA engine and a CPU cache refill port.
- Grants whole bus cycles with round-robin fairness. A per-grant strobe budget keeps one master from starving the other.
- Tracks outstanding requests so the bus changes hands only after all responses have drained.

---
 rtl/wb_ddr3_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_ddr3_arbiter.sv
// wb_ddr3_arbiter
// Shares the pipelined Wishbone slave port of the DDR3 controller between two
// masters. Whole bus cycles are granted round-robin. A per-grant strobe budget
// stops one master from starving the other. The bus changes hands only after
// every accepted request has been answered.
//
// Ports:
//   clock, RST_N            system clock, asynchronous active-low reset
//   m0_* / m1_*             master-side Wishbone (cyc/stb/we/addr/data/sel in,
//                           stall/ack/err/rdata out)
//   s_*                     slave-side Wishbone toward the DDR3 controller
//
// Parameters:
//   MAX_BURST        strobes accepted per grant before yielding (0 = unlimited)
//   MAX_OUTSTANDING  cap on accepted-but-unanswered requests at the slave

module wb_ddr3_arbiter #(
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clock,
    input  logic        RST_N,

    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [63:0] m0_data,
    input  logic [7:0]  m0_sel,
    output logic        m0_stall,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [63:0] m0_rdata,

    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [63:0] m1_data,
    input  logic [7:0]  m1_sel,
    output logic        m1_stall,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [63:0] m1_rdata,

    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [63:0] s_data,
    output logic [7:0]  s_sel,
    input  logic        s_stall,
    input  logic        s_ack,
    input  logic        s_err,
    input  logic [63:0] s_rdata
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic          BURST_ON  = (MAX_BURST != 0);

    typedef enum logic [2:0] {IDLE, OWN0, OWN1, DRAIN0, DRAIN1} state_t;

    state_t        state, state_next;
    logic          last, last_next;
    logic [OW-1:0] outstanding;
    logic [BW-1:0] burst_cnt;

    logic owner, granted, owning;
    logic k_cyc, o_cyc, k_stb;
    logic limit, block, accept, resp, budget_hit;

    // Read data is broadcast; only the ack/err strobes say who it belongs to.
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    // Decode the current owner and select its request signals.
    always_comb begin
        granted = (state != IDLE);
        owning  = (state == OWN0) || (state == OWN1);
        owner   = (state == OWN1) || (state == DRAIN1);
        k_cyc   = owner ? m1_cyc : m0_cyc;
        o_cyc   = owner ? m0_cyc : m1_cyc;
        k_stb   = owner ? m1_stb : m0_stb;
        limit   = BURST_ON && (burst_cnt == BURST_MAX);
        block   = (outstanding == OUT_MAX) || limit;
    end

    // Slave-side request mux and master-side response routing. A master that
    // does not own the bus always sees stall and never sees a response.
    // Responses arriving with nothing outstanding are dropped.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_addr   = '0;
        s_data   = '0;
        s_sel    = '0;
        m0_stall = 1'b1;
        m1_stall = 1'b1;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_err   = 1'b0;
        m1_err   = 1'b0;
        if (granted) begin
            s_cyc  = k_cyc;
            s_we   = owner ? m1_we   : m0_we;
            s_addr = owner ? m1_addr : m0_addr;
            s_data = owner ? m1_data : m0_data;
            s_sel  = owner ? m1_sel  : m0_sel;
            if (owning) begin
                s_stb = k_cyc && k_stb && !block;
            end
            if (owner) begin
                m1_stall = owning ? (s_stall || block) : 1'b1;
                m1_ack   = s_ack && (outstanding != '0);
                m1_err   = s_err && (outstanding != '0);
            end else begin
                m0_stall = owning ? (s_stall || block) : 1'b1;
                m0_ack   = s_ack && (outstanding != '0);
                m0_err   = s_err && (outstanding != '0);
            end
        end
    end

    // Handshake events. budget_hit also fires in the cycle where the strobe
    // that fills the budget is accepted, so the handover starts without a
    // wasted cycle.
    always_comb begin
        accept     = s_stb && !s_stall;
        resp       = (s_ack || s_err) && (outstanding != '0);
        budget_hit = BURST_ON && (limit || (accept && (burst_cnt == BURST_MAX - BW'(1))));
    end

    // Arbitration: round-robin in IDLE, yield on budget when the other master
    // waits, release once responses drain or the owner cancels by dropping cyc.
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (m0_cyc && (!m1_cyc || last)) begin
                    state_next = OWN0;
                end else if (m1_cyc) begin
                    state_next = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!k_cyc) begin
                    state_next = IDLE;
                    last_next  = owner;
                end else if (budget_hit && o_cyc) begin
                    state_next = owner ? DRAIN1 : DRAIN0;
                end
            end
            DRAIN0, DRAIN1: begin
                if (!k_cyc || (outstanding == '0) ||
                    ((outstanding == OW'(1)) && resp)) begin
                    state_next = IDLE;
                    last_next  = owner;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and last-owner registers. last resets to 1 so m0 wins the first tie.
    always_ff @(posedge clock or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    // Counters are held at zero in IDLE, which also clears them for the next
    // grant. A cancel throws away the outstanding count because the controller
    // abandons those requests.
    always_ff @(posedge clock or negedge RST_N) begin
        if (!RST_N) begin
            outstanding <= '0;
            burst_cnt   <= '0;
        end else if (state == IDLE) begin
            outstanding <= '0;
            burst_cnt   <= '0;
        end else if (!k_cyc) begin
            outstanding <= '0;
        end else begin
            if (accept && !resp) begin
                outstanding <= outstanding + OW'(1);
            end else if (!accept && resp) begin
                outstanding <= outstanding - OW'(1);
            end
            if (BURST_ON && accept && !limit) begin
                burst_cnt <= burst_cnt + BW'(1);
            end
        end
    end

endmodule
